// File: rtl/adc_cond_pkg.sv
// adc_cond_pkg
// Shared helpers for the ADC front-end conditioner.
//   derand(x, rnd, w) : undo LTC-style output randomisation on a w-bit word
//   abs_sat(x, w)     : saturating magnitude of a w-bit two's-complement word
//   FS_POS(w)/FS_NEG(w): positive / negative full-scale bit patterns
// All helpers work on a wide carrier word so one function serves every
// channel width; callers zero-extend in and slice the low bits back out.
package adc_cond_pkg;

    localparam int MAXW = 64;

    typedef logic [MAXW-1:0] word_t;

    function automatic word_t width_mask(input int w);
        if (w >= MAXW) begin
            return '1;
        end
        return (word_t'(1) << w) - word_t'(1);
    endfunction

    function automatic word_t FS_POS(input int w);
        return (word_t'(1) << (w - 1)) - word_t'(1);
    endfunction

    function automatic word_t FS_NEG(input int w);
        return word_t'(1) << (w - 1);
    endfunction

    // With randomisation on, every bit above bit 0 was XORed with bit 0 by the ADC.
    function automatic word_t derand(input word_t x, input logic rnd, input int w);
        if (rnd && x[0]) begin
            return x ^ (width_mask(w) & ~word_t'(1));
        end
        return x;
    endfunction

    // The most negative code has no positive twin, so it clamps to +full scale.
    function automatic word_t abs_sat(input word_t x, input int w);
        logic neg;
        neg = ((x >> (w - 1)) & word_t'(1)) != '0;
        if (!neg) begin
            return x;
        end
        if (x == FS_NEG(w)) begin
            return FS_POS(w);
        end
        return (~x + word_t'(1)) & width_mask(w);
    endfunction

endpackage

// File: rtl/adc_ch_cond.sv
// adc_ch_cond
// One conditioner channel: input register, derandomise/format stage,
// overrange stretcher and running peak-magnitude tracker.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   rand_en, fmt : derandomise enable, offset-binary select (raw pins)
//   ovr_raw      : raw overrange pin
//   adc_raw      : raw W-bit sample
//   run_zero     : zero the running maximum this clock (wrap or clear)
//   peak_load    : latch the completed window peak this clock
//   adc_out      : conditioned two's-complement sample
//   ovr_out      : stretched overrange flag, aligned with adc_out
//   peak_out     : last completed window peak magnitude
module adc_ch_cond
    import adc_cond_pkg::*;
#(
    parameter int W        = 16,
    parameter int OVR_HOLD = 1024
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rand_en,
    input  logic         fmt,
    input  logic         ovr_raw,
    input  logic [W-1:0] adc_raw,
    input  logic         run_zero,
    input  logic         peak_load,
    output logic [W-1:0] adc_out,
    output logic         ovr_out,
    output logic [W-2:0] peak_out
);

    localparam int            CW          = (OVR_HOLD > 1) ? $clog2(OVR_HOLD) : 1;
    localparam logic [CW-1:0] HOLD_LOAD   = CW'(OVR_HOLD - 1);
    localparam word_t         FS_POS_FULL = FS_POS(W);
    localparam word_t         FS_NEG_FULL = FS_NEG(W);
    localparam logic [W-1:0]  FS_P        = FS_POS_FULL[W-1:0];
    localparam logic [W-1:0]  FS_N        = FS_NEG_FULL[W-1:0];

    logic [W-1:0]  s1_x;
    logic          s1_ovr;
    logic          s1_rand;
    logic          s1_fmt;
    word_t         dr_full;
    logic [W-1:0]  d;
    logic          trig;
    logic          trig_r;
    logic [CW-1:0] ovr_cnt;
    word_t         mag_full;
    logic [W-2:0]  mag;
    logic [W-2:0]  run_max;
    logic [W-2:0]  pk_next;
    logic          unused_bits;

    // Control pins travel with the sample they were captured alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_x    <= '0;
            s1_ovr  <= 1'b0;
            s1_rand <= 1'b0;
            s1_fmt  <= 1'b0;
        end else begin
            s1_x    <= adc_raw;
            s1_ovr  <= ovr_raw;
            s1_rand <= rand_en;
            s1_fmt  <= fmt;
        end
    end

    assign dr_full = derand(word_t'(s1_x), s1_rand, W);
    assign d       = dr_full[W-1:0] ^ {s1_fmt, {(W-1){1'b0}}};
    assign trig    = s1_ovr | (d == FS_P) | (d == FS_N);

    // The counter loads from the registered trigger, one clock after the
    // trigger itself, so trig_r covers hold clock 1 and the counter covers
    // the remaining OVR_HOLD-1 clocks.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_out <= '0;
            trig_r  <= 1'b0;
            ovr_cnt <= '0;
        end else begin
            adc_out <= d;
            trig_r  <= trig;
            if (trig_r) begin
                ovr_cnt <= HOLD_LOAD;
            end else if (ovr_cnt != '0) begin
                ovr_cnt <= ovr_cnt - CW'(1);
            end
        end
    end

    assign ovr_out = trig_r | (ovr_cnt != '0);

    assign mag_full = abs_sat(word_t'(adc_out), W);
    assign mag      = mag_full[W-2:0];

    always_comb begin
        pk_next = run_max;
        if (mag > run_max) begin
            pk_next = mag;
        end
    end

    // On the wrap clock the current sample still counts toward the
    // finishing window before the running maximum restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_max  <= '0;
            peak_out <= '0;
        end else begin
            if (run_zero) begin
                run_max <= '0;
            end else begin
                run_max <= pk_next;
            end
            if (peak_load) begin
                peak_out <= pk_next;
            end
        end
    end

    assign unused_bits = ^{dr_full[MAXW-1:W], mag_full[MAXW-1:W-1]};

endmodule

// File: rtl/adc_derand_cond.sv
// adc_derand_cond
// Multi-channel ADC front-end conditioner between the ADC pins and the DDC.
// Ports:
//   clka         : sample clock
//   local_reset  : asynchronous active-high reset
//   ADC_rand_i   : derandomise enable (all channels)
//   ADC_fmt_i    : 1 = offset-binary input, 0 = two's complement input
//   ADC_ovr_i    : raw overrange pin per channel
//   ADC_i        : raw samples, channel c at [c*W +: W]
//   peak_clr_i   : synchronous restart of the peak window
//   ADC_o        : conditioned samples (latency 2)
//   ADC_ovr_o    : stretched overrange flags
//   ADC_peak_o   : last completed window peak magnitude per channel
//   peak_valid_o : one-clock strobe when ADC_peak_o updates
module adc_derand_cond
    import adc_cond_pkg::*;
#(
    parameter int W        = 16,
    parameter int NCH      = 1,
    parameter int OVR_HOLD = 1024,
    parameter int PEAK_WIN = 65536
) (
    input  logic                 clka,
    input  logic                 local_reset,
    input  logic                 ADC_rand_i,
    input  logic                 ADC_fmt_i,
    input  logic [NCH-1:0]       ADC_ovr_i,
    input  logic [NCH*W-1:0]     ADC_i,
    input  logic                 peak_clr_i,
    output logic [NCH*W-1:0]     ADC_o,
    output logic [NCH-1:0]       ADC_ovr_o,
    output logic [NCH*(W-1)-1:0] ADC_peak_o,
    output logic                 peak_valid_o
);

    localparam int             WCW      = $clog2(PEAK_WIN);
    localparam logic [WCW-1:0] WIN_LAST = WCW'(PEAK_WIN - 1);

    logic [WCW-1:0] win_cnt;
    logic           wrap;
    logic           peak_load;
    logic           run_zero;

    assign wrap      = (win_cnt == WIN_LAST);
    // A clear landing on the wrap clock suppresses the latch and the strobe.
    assign peak_load = wrap & ~peak_clr_i;
    assign run_zero  = wrap | peak_clr_i;

    // Shared window counter; a clear restarts the window from count 0.
    always_ff @(posedge clka or posedge local_reset) begin
        if (local_reset) begin
            win_cnt      <= '0;
            peak_valid_o <= 1'b0;
        end else begin
            if (peak_clr_i || wrap) begin
                win_cnt <= '0;
            end else begin
                win_cnt <= win_cnt + WCW'(1);
            end
            peak_valid_o <= peak_load;
        end
    end

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        adc_ch_cond #(
            .W        (W),
            .OVR_HOLD (OVR_HOLD)
        ) u_ch (
            .clk       (clka),
            .rst       (local_reset),
            .rand_en   (ADC_rand_i),
            .fmt       (ADC_fmt_i),
            .ovr_raw   (ADC_ovr_i[c]),
            .adc_raw   (ADC_i[c*W +: W]),
            .run_zero  (run_zero),
            .peak_load (peak_load),
            .adc_out   (ADC_o[c*W +: W]),
            .ovr_out   (ADC_ovr_o[c]),
            .peak_out  (ADC_peak_o[c*(W-1) +: (W-1)])
        );
    end

endmodule

// File: doc/adc_derand_cond.md
# adc_derand_cond

Parametrised ADC front-end conditioner, the multi-channel successor to the single-channel QS1R derandomizer. Per channel it registers raw ADC words, optionally removes LTC-style output randomisation and converts offset-binary to two's complement, stretches overrange events, and measures windowed peak magnitude. It sits between the ADC pins and the DDC input, in the `clka` domain.

## Interface
- `W`, default 16: ADC sample width in bits (≥4).
- `NCH`, default 1: number of channels.
- `OVR_HOLD`, default 1024: overrange stretch length in clocks (≥1).
- `PEAK_WIN`, default 65536: peak-measurement window length in clocks (≥2).

Ports:
- `clka` in 1: sample clock; the only clock in the block.
- `local_reset` in 1: reset, asynchronous, active-high.
- `ADC_rand_i` in 1: derandomize enable, shared by all channels.
- `ADC_fmt_i` in 1: 1 = input is offset binary, so invert the MSB; 0 = input is already two's complement.
- `ADC_ovr_i` in NCH: raw overrange pin, one per channel.
- `ADC_i` in NCH*W: raw samples, channel c at `[c*W +: W]`.
- `peak_clr_i` in 1: synchronous restart of the peak window.
- `ADC_o` out NCH*W: conditioned two's-complement samples.
- `ADC_ovr_o` out NCH: stretched overrange flag.
- `ADC_peak_o` out NCH*(W-1): last completed window peak |x|.
- `peak_valid_o` out 1: one-cycle strobe when `ADC_peak_o` updates.

## Operation
- **S1, input register.** Capture `ADC_i`, `ADC_ovr_i`, `ADC_rand_i` and `ADC_fmt_i` every clock. Control changes therefore apply to whole samples only.
- **S2, derandomize and format.**
  - If rand=1 and bit0=1: d = {~x[W-1:1], x[0]}; otherwise d = x.
  - If fmt=1: d[W-1] inverted.
  - Register the result as `ADC_o`.
- **Overrange trigger.** A sample triggers when its registered ovr bit is 1, or when its S2 result equals full scale (2^(W-1)-1 or -2^(W-1)).
- **Overrange stretch.**
  - A per-channel counter loads OVR_HOLD-1 on a trigger, else decrements toward 0.
  - `ADC_ovr_o` = trigger registered with the sample, OR counter≠0.
  - A retrigger while the counter is nonzero reloads it.
- **Peak measurement.**
  - mag = |ADC_o|, saturating: -2^(W-1) maps to 2^(W-1)-1, width W-1.
  - A running max per channel updates every clock.
  - A shared window counter wraps at PEAK_WIN-1.
  - On the wrap cycle: `ADC_peak_o` takes max(running, mag), running resets to 0, `peak_valid_o` pulses.
- **Peak clear.** `peak_clr_i`=1 zeroes the window counter and all running maxima. No valid pulse is issued and `ADC_peak_o` is held. If a clear coincides with the wrap cycle, the clear wins.
- **Reset.** `local_reset` clears all pipeline registers, counters and outputs to 0 immediately, including mid-window and mid-stretch. The window restarts from count 0 after release.

## Timing
- `ADC_i` sampled at edge n appears on `ADC_o` after edge n+2. Latency is 2, throughput is 1 sample/clock/channel.
- `ADC_ovr_o` is cycle-aligned with the triggering `ADC_o` sample. It stays high for exactly OVR_HOLD clocks after the last trigger, counting the trigger cycle as clock 1.
- Peak path adds 1 register: the sample sampled at `ADC_i` edge n contributes to a window whose `peak_valid_o` can fire no earlier than edge n+3.
- With no clear, `peak_valid_o` fires every PEAK_WIN clocks. The first pulse comes PEAK_WIN clocks after reset release. Pipeline zeros after reset contribute magnitude 0.
- A toggle of `ADC_rand_i` or `ADC_fmt_i` at edge n affects exactly the samples with `ADC_i` at edge ≥n.

## Structure
- Package `adc_cond_pkg` holds:
  - function `derand(x, rand)`;
  - function `abs_sat(x)`;
  - full-scale constants `FS_POS` and `FS_NEG` as functions of W.
- Sub-module `adc_ch_cond`, one instance per channel via generate: S1/S2 pipeline, overrange counter, running max.
- Top level holds the shared window counter, the clear/wrap arbitration, and the `ADC_peak_o` latch enable fanned out to all channels.

## Test plan
- **Derandomize:** W=16, rand=1, fmt=0, `ADC_i`=16'h1235 → `ADC_o`=16'hEDCB two cycles later. Input 16'h1234 passes unchanged. With rand=0, 16'h1235 passes unchanged.
- **Format:** fmt=1, rand=0, `ADC_i`=16'h8000 → 16'h0000; 16'h0000 → 16'h8000. Toggle fmt mid-stream and check the switch lands on an exact sample boundary.
- **Overrange:** OVR_HOLD=4. One-cycle `ADC_ovr_i` pulse → `ADC_ovr_o` high exactly 4 cycles, aligned with that sample. A retrigger at the 3rd cycle extends to 6 cycles total. A full-scale 16'h7FFF sample triggers with the pin low.
- **Peak:** PEAK_WIN=8, NCH=2. Ch0 samples include -5 and +3, ch1 includes 16'h8000. Expect `ADC_peak_o` = 5 and 32767, and `peak_valid_o` every 8 clocks.
- **Clear collision:** assert `peak_clr_i` on the wrap cycle → no valid pulse, peak output held, next pulse 8 clocks later.
- **Reset mid-operation:** assert `local_reset` mid-stretch and mid-window → all outputs 0 asynchronously. After release, the first valid pulse comes PEAK_WIN clocks later.
